// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types for the EX-stage hazard controller.
//   fwd_sel_e : operand-mux select codes driven on forwardA/forwardB
//   state_e   : sequencing FSM states
package ex_hazard_ctrl_pkg;

  localparam int unsigned RegAddrWidth = 5;

  typedef enum logic [1:0] {
    FwdReg   = 2'b00,  // operand from register file
    FwdWb    = 2'b01,  // operand from WB_data
    FwdExMem = 2'b10   // operand from EX_MEM_alu_out
  } fwd_sel_e;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StMcBusy = 1'b1
  } state_e;

endpackage

// File: rtl/ex_hazard_ctrl_fwd.sv
// Combinational forward-select for both EX operands.
// Ports:
//   EX_MEM_rd_i/EX_MEM_wen_i  dest/write-enable of instr in MEM
//   MEM_WB_rd_i/MEM_WB_wen_i  dest/write-enable of instr in WB
//   ID_EX_rs1_i/ID_EX_rs2_i   sources of instr in EX
//   forward_a_o/forward_b_o   mux selects (fwd_sel_e encoding)
module ex_hazard_ctrl_fwd
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = RegAddrWidth
) (
  input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd_i,
  input  logic                      EX_MEM_wen_i,
  input  logic [REG_ADDR_WIDTH-1:0] MEM_WB_rd_i,
  input  logic                      MEM_WB_wen_i,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rs2_i,
  output fwd_sel_e                  forward_a_o,
  output fwd_sel_e                  forward_b_o
);

  // x0 is hardwired zero, so a write to it is never a real producer.
  logic ex_mem_live, mem_wb_live;
  assign ex_mem_live = EX_MEM_wen_i && (EX_MEM_rd_i != '0);
  assign mem_wb_live = MEM_WB_wen_i && (MEM_WB_rd_i != '0);

  // The younger producer (EX/MEM) takes precedence over MEM/WB.
  always_comb begin
    forward_a_o = FwdReg;
    if (ex_mem_live && (EX_MEM_rd_i == ID_EX_rs1_i)) begin
      forward_a_o = FwdExMem;
    end else if (mem_wb_live && (MEM_WB_rd_i == ID_EX_rs1_i)) begin
      forward_a_o = FwdWb;
    end
  end

  always_comb begin
    forward_b_o = FwdReg;
    if (ex_mem_live && (EX_MEM_rd_i == ID_EX_rs2_i)) begin
      forward_b_o = FwdExMem;
    end else if (mem_wb_live && (MEM_WB_rd_i == ID_EX_rs2_i)) begin
      forward_b_o = FwdWb;
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage sequencing: operand forwarding, load-use stall, taken-branch squash and
// multi-cycle (mul/div) hold. Outputs are Mealy on state + inputs.
// Ports:
//   clk_i, reset_i                     clock, synchronous active-high reset
//   IF_ID_* / ID_EX_* / EX_MEM_* / MEM_WB_*  pipeline register fields
//   EX_branch_taken_i                  taken branch/jump resolved in EX
//   forwardA_o/forwardB_o              00 regfile, 01 WB_data, 10 EX_MEM_alu_out
//   pc/IF_ID/ID_EX write enables, IF_ID/ID_EX/EX_MEM flushes
//   mc_start_o, mc_sel_o, busy_o       multi-cycle unit control and status
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = RegAddrWidth,
  parameter int unsigned MC_LATENCY     = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2_i,
  input  logic                      IF_ID_use_rs1_i,
  input  logic                      IF_ID_use_rs2_i,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rs2_i,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd_i,
  input  logic                      ID_EX_mem_read_i,
  input  logic                      ID_EX_mc_op_i,
  input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd_i,
  input  logic                      EX_MEM_wen_i,
  input  logic [REG_ADDR_WIDTH-1:0] MEM_WB_rd_i,
  input  logic                      MEM_WB_wen_i,
  input  logic                      EX_branch_taken_i,
  output logic [1:0]                forwardA_o,
  output logic [1:0]                forwardB_o,
  output logic                      pc_write_en_o,
  output logic                      IF_ID_write_en_o,
  output logic                      IF_ID_flush_o,
  output logic                      ID_EX_write_en_o,
  output logic                      ID_EX_flush_o,
  output logic                      EX_MEM_flush_o,
  output logic                      mc_start_o,
  output logic                      mc_sel_o,
  output logic                      busy_o
);

  // Start cycle counts as one cycle of occupancy; the count reaching zero marks the result cycle.
  localparam logic [3:0] CntInit = 4'(MC_LATENCY - 2);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  fwd_sel_e fwd_a, fwd_b;

  ex_hazard_ctrl_fwd #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd (
    .EX_MEM_rd_i  (EX_MEM_rd_i),
    .EX_MEM_wen_i (EX_MEM_wen_i),
    .MEM_WB_rd_i  (MEM_WB_rd_i),
    .MEM_WB_wen_i (MEM_WB_wen_i),
    .ID_EX_rs1_i  (ID_EX_rs1_i),
    .ID_EX_rs2_i  (ID_EX_rs2_i),
    .forward_a_o  (fwd_a),
    .forward_b_o  (fwd_b)
  );

  // Forwarding is neutral while reset is held.
  assign forwardA_o = reset_i ? FwdReg : fwd_a;
  assign forwardB_o = reset_i ? FwdReg : fwd_b;

  logic load_use;
  assign load_use = ID_EX_mem_read_i && (ID_EX_rd_i != '0) &&
                    ((IF_ID_use_rs1_i && (IF_ID_rs1_i == ID_EX_rd_i)) ||
                     (IF_ID_use_rs2_i && (IF_ID_rs2_i == ID_EX_rd_i)));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    pc_write_en_o    = 1'b1;
    IF_ID_write_en_o = 1'b1;
    IF_ID_flush_o    = 1'b0;
    ID_EX_write_en_o = 1'b1;
    ID_EX_flush_o    = 1'b0;
    EX_MEM_flush_o   = 1'b0;
    mc_start_o       = 1'b0;
    mc_sel_o         = 1'b0;
    busy_o           = 1'b0;

    if (!reset_i) begin
      unique case (state_q)
        StIdle: begin
          if (EX_branch_taken_i) begin
            // Squash wrong-path instrs in IF/ID and ID/EX; beats any load-use stall.
            IF_ID_flush_o = 1'b1;
            ID_EX_flush_o = 1'b1;
          end else if (ID_EX_mc_op_i) begin
            mc_start_o       = 1'b1;
            pc_write_en_o    = 1'b0;
            IF_ID_write_en_o = 1'b0;
            ID_EX_write_en_o = 1'b0;
            EX_MEM_flush_o   = 1'b1;
            cnt_d            = CntInit;
            state_d          = StMcBusy;
          end else if (load_use) begin
            pc_write_en_o    = 1'b0;
            IF_ID_write_en_o = 1'b0;
            ID_EX_flush_o    = 1'b1;
          end
        end
        StMcBusy: begin
          busy_o = 1'b1;
          if (cnt_q != '0) begin
            pc_write_en_o    = 1'b0;
            IF_ID_write_en_o = 1'b0;
            ID_EX_write_en_o = 1'b0;
            EX_MEM_flush_o   = 1'b1;
            cnt_d            = cnt_q - 4'd1;
          end else begin
            // Result cycle: pipeline advances and the unit's result enters EX/MEM.
            mc_sel_o = 1'b1;
            state_d  = StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
module tb_ex_hazard_ctrl;

  localparam int unsigned W = 5;
  localparam int unsigned L = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [W-1:0] if_rs1, if_rs2, ex_rs1, ex_rs2, ex_rd, em_rd, mw_rd;
  logic         use1, use2, mem_read, mc_op, em_wen, mw_wen, br;
  logic [1:0]   fa, fb;
  logic         pc_we, ifid_we, ifid_fl, idex_we, idex_fl, exmem_fl, mc_start, mc_sel, busy;

  ex_hazard_ctrl #(.REG_ADDR_WIDTH(W), .MC_LATENCY(L)) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .IF_ID_rs1_i       (if_rs1),
    .IF_ID_rs2_i       (if_rs2),
    .IF_ID_use_rs1_i   (use1),
    .IF_ID_use_rs2_i   (use2),
    .ID_EX_rs1_i       (ex_rs1),
    .ID_EX_rs2_i       (ex_rs2),
    .ID_EX_rd_i        (ex_rd),
    .ID_EX_mem_read_i  (mem_read),
    .ID_EX_mc_op_i     (mc_op),
    .EX_MEM_rd_i       (em_rd),
    .EX_MEM_wen_i      (em_wen),
    .MEM_WB_rd_i       (mw_rd),
    .MEM_WB_wen_i      (mw_wen),
    .EX_branch_taken_i (br),
    .forwardA_o        (fa),
    .forwardB_o        (fb),
    .pc_write_en_o     (pc_we),
    .IF_ID_write_en_o  (ifid_we),
    .IF_ID_flush_o     (ifid_fl),
    .ID_EX_write_en_o  (idex_we),
    .ID_EX_flush_o     (idex_fl),
    .EX_MEM_flush_o    (exmem_fl),
    .mc_start_o        (mc_start),
    .mc_sel_o          (mc_sel),
    .busy_o            (busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: "in an mc op" flag plus cycles elapsed since its start cycle.
  bit m_busy = 1'b0;
  int m_age  = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_age  <= 0;
    end else if (!m_busy) begin
      if (!br && mc_op) begin
        m_busy <= 1'b1;
        m_age  <= 1;
      end
    end else if (m_age == L - 1) begin
      m_busy <= 1'b0;
    end else begin
      m_age <= m_age + 1;
    end
  end

  function automatic int fwd_ref(input logic [W-1:0] rs);
    if (em_wen && em_rd != 0 && em_rd == rs) return 2;
    if (mw_wen && mw_rd != 0 && mw_rd == rs) return 1;
    return 0;
  endfunction

  // Compare process: every cycle, on the falling edge, all outputs against the model.
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      int e_fa, e_fb;
      bit e_pc, e_ifwe, e_iffl, e_idwe, e_idfl, e_emfl, e_start, e_sel, e_busy, lu;
      e_fa = 0; e_fb = 0;
      e_pc = 1; e_ifwe = 1; e_idwe = 1;
      e_iffl = 0; e_idfl = 0; e_emfl = 0; e_start = 0; e_sel = 0; e_busy = 0;
      lu = mem_read && ex_rd != 0 &&
           ((use1 && if_rs1 == ex_rd) || (use2 && if_rs2 == ex_rd));
      if (!reset) begin
        e_fa = fwd_ref(ex_rs1);
        e_fb = fwd_ref(ex_rs2);
        if (m_busy) begin
          e_busy = 1;
          if (m_age == L - 1) e_sel = 1;
          else begin
            e_pc = 0; e_ifwe = 0; e_idwe = 0; e_emfl = 1;
          end
        end else if (br) begin
          e_iffl = 1; e_idfl = 1;
        end else if (mc_op) begin
          e_start = 1; e_pc = 0; e_ifwe = 0; e_idwe = 0; e_emfl = 1;
        end else if (lu) begin
          e_pc = 0; e_ifwe = 0; e_idfl = 1;
        end
      end
      chk("m_forwardA", fa, e_fa);
      chk("m_forwardB", fb, e_fb);
      chk("m_pc_write_en", pc_we, e_pc);
      chk("m_IF_ID_write_en", ifid_we, e_ifwe);
      chk("m_IF_ID_flush", ifid_fl, e_iffl);
      chk("m_ID_EX_write_en", idex_we, e_idwe);
      chk("m_ID_EX_flush", idex_fl, e_idfl);
      chk("m_EX_MEM_flush", exmem_fl, e_emfl);
      chk("m_mc_start", mc_start, e_start);
      chk("m_mc_sel", mc_sel, e_sel);
      chk("m_busy", busy, e_busy);
    end
  end

  task automatic clear_inputs();
    if_rs1 = '0; if_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; em_rd = '0; mw_rd = '0;
    use1 = 0; use2 = 0; mem_read = 0; mc_op = 0; em_wen = 0; mw_wen = 0; br = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_pc_we", pc_we, 1);
    chk("rst_busy", busy, 0);
    next_cycle();
    reset = 1'b0;

    // 1: EX/MEM beats MEM/WB, then MEM/WB alone
    em_rd = 5; em_wen = 1; mw_rd = 5; mw_wen = 1; ex_rs1 = 5;
    @(negedge clk);
    chk("t1_fwdA_exmem", fa, 2);
    #1 em_wen = 0;
    #1 chk("t1_fwdA_wb", fa, 1);

    // 2: x0 never forwards
    next_cycle();
    clear_inputs();
    em_rd = 0; em_wen = 1; mw_rd = 0; mw_wen = 1; ex_rs2 = 0;
    @(negedge clk);
    chk("t2_fwdB_x0", fb, 0);

    // 3: load-use single stall
    next_cycle();
    clear_inputs();
    mem_read = 1; ex_rd = 7; if_rs2 = 7; use2 = 1;
    @(negedge clk);
    chk("t3_pc_we", pc_we, 0);
    chk("t3_ifid_we", ifid_we, 0);
    chk("t3_idex_flush", idex_fl, 1);
    next_cycle();
    mem_read = 0; ex_rd = 0;
    @(negedge clk);
    chk("t3_after_pc_we", pc_we, 1);
    chk("t3_after_idex_flush", idex_fl, 0);

    // 4: branch overrides load-use
    next_cycle();
    mem_read = 1; ex_rd = 7; if_rs2 = 7; use2 = 1; br = 1;
    @(negedge clk);
    chk("t4_ifid_flush", ifid_fl, 1);
    chk("t4_idex_flush", idex_fl, 1);
    chk("t4_pc_we", pc_we, 1);

    // 5: multi-cycle op, latency 4
    next_cycle();
    clear_inputs();
    mc_op = 1;
    @(negedge clk);
    chk("t5_T0_start", mc_start, 1);
    chk("t5_T0_pc_we", pc_we, 0);
    for (int t = 1; t <= 2; t++) begin
      next_cycle();
      @(negedge clk);
      chk("t5_stall_start", mc_start, 0);
      chk("t5_stall_pc_we", pc_we, 0);
      chk("t5_stall_busy", busy, 1);
    end
    next_cycle();
    @(negedge clk);
    chk("t5_T3_sel", mc_sel, 1);
    chk("t5_T3_busy", busy, 1);
    chk("t5_T3_pc_we", pc_we, 1);
    next_cycle();
    mc_op = 0;
    @(negedge clk);
    chk("t5_T4_busy", busy, 0);
    chk("t5_T4_sel", mc_sel, 0);

    // 6: reset during op abandons it
    next_cycle();
    mc_op = 1;
    next_cycle();
    reset = 1; mc_op = 0;
    @(negedge clk);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_pc_we", pc_we, 1);
    next_cycle();
    reset = 0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("t6_no_sel", mc_sel, 0);
      chk("t6_idle_busy", busy, 0);
      next_cycle();
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 59) == 0);
      if_rs1   = W'($urandom_range(0, 7));
      if_rs2   = W'($urandom_range(0, 7));
      ex_rs1   = W'($urandom_range(0, 7));
      ex_rs2   = W'($urandom_range(0, 7));
      ex_rd    = W'($urandom_range(0, 7));
      em_rd    = W'($urandom_range(0, 7));
      mw_rd    = W'($urandom_range(0, 7));
      use1     = 1'($urandom_range(0, 1));
      use2     = 1'($urandom_range(0, 1));
      mem_read = ($urandom_range(0, 2) == 0);
      mc_op    = ($urandom_range(0, 5) == 0);
      em_wen   = 1'($urandom_range(0, 1));
      mw_wen   = 1'($urandom_range(0, 1));
      br       = ($urandom_range(0, 6) == 0);
      next_cycle();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
